// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Shares the single dcache controller port between the PTW (port 0), the
// load unit (port 1) and the store unit (port 2). A winner is picked in IDLE
// and owns the controller until the transaction completes or is withdrawn.
// Fixed priority PTW > load > store, except that a store which has been
// bypassed MAX_BYPASS times in a row wins the next arbitration.

module dcache_port_arbiter #(
    parameter int unsigned MAX_BYPASS = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] req_i,
    input  logic [2:0] we_i,
    output logic [2:0] gnt_o,
    output logic       cache_req_o,
    output logic       cache_we_o,
    output logic [1:0] cache_port_o,
    input  logic       cache_gnt_i,
    input  logic       cache_done_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DONE
    } state_e;

    localparam logic [3:0] BYPASS_LIMIT = 4'(MAX_BYPASS);
    localparam logic [1:0] PORT_PTW     = 2'd0;
    localparam logic [1:0] PORT_LOAD    = 2'd1;
    localparam logic [1:0] PORT_STORE   = 2'd2;

    state_e     state_q, state_d;
    logic [1:0] port_q, port_d;
    logic [3:0] bypass_cnt_q, bypass_cnt_d;

    logic [1:0] winner;
    logic       own_req;
    logic       own_we;
    logic       accept;

    // Pick the next owner: starved store first, then fixed priority
    always_comb begin
        winner = PORT_PTW;
        if (req_i[2] && (bypass_cnt_q == BYPASS_LIMIT)) begin
            winner = PORT_STORE;
        end else if (req_i[0]) begin
            winner = PORT_PTW;
        end else if (req_i[1]) begin
            winner = PORT_LOAD;
        end else if (req_i[2]) begin
            winner = PORT_STORE;
        end
    end

    // Select request and write-enable of the current owner
    always_comb begin
        own_req = 1'b0;
        own_we  = 1'b0;
        case (port_q)
            PORT_PTW: begin
                own_req = req_i[0];
                own_we  = we_i[0];
            end
            PORT_LOAD: begin
                own_req = req_i[1];
                own_we  = we_i[1];
            end
            PORT_STORE: begin
                own_req = req_i[2];
                own_we  = we_i[2];
            end
            default: begin
                own_req = 1'b0;
                own_we  = 1'b0;
            end
        endcase
    end

    assign accept = (state_q == REQ) && cache_gnt_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; no preemption once an owner is chosen
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cache_gnt_i) begin
                    state_d = cache_done_i ? IDLE : WAIT_DONE;
                end else if (!own_req) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (cache_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Owner latch and store-starvation counter next values
    always_comb begin
        port_d       = port_q;
        bypass_cnt_d = bypass_cnt_q;

        if ((state_q == IDLE) && (|req_i)) begin
            port_d = winner;
        end

        if (accept) begin
            if (port_q == PORT_STORE) begin
                bypass_cnt_d = '0;
            end else if (req_i[2]) begin
                bypass_cnt_d = (bypass_cnt_q >= BYPASS_LIMIT) ? BYPASS_LIMIT
                                                              : bypass_cnt_q + 4'd1;
            end
        end

        if ((state_q == IDLE) && !req_i[2]) begin
            bypass_cnt_d = '0;
        end
    end

    // Owner and bypass counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            port_q       <= '0;
            bypass_cnt_q <= '0;
        end else begin
            port_q       <= port_d;
            bypass_cnt_q <= bypass_cnt_d;
        end
    end

    // Outputs: forward the owner's request in REQ, hold the port ID in WAIT_DONE
    always_comb begin
        gnt_o        = '0;
        cache_req_o  = 1'b0;
        cache_we_o   = 1'b0;
        cache_port_o = '0;
        busy_o       = 1'b0;
        case (state_q)
            REQ: begin
                cache_req_o    = own_req;
                cache_we_o     = own_we;
                cache_port_o   = port_q;
                gnt_o[port_q]  = cache_gnt_i;
                busy_o         = 1'b1;
            end
            WAIT_DONE: begin
                cache_port_o = port_q;
                busy_o       = 1'b1;
            end
            default: begin
                gnt_o        = '0;
                cache_req_o  = 1'b0;
                cache_we_o   = 1'b0;
                cache_port_o = '0;
                busy_o       = 1'b0;
            end
        endcase
    end

    // Structural invariants of the arbiter
    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));
    a_port_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
        port_q != 2'd3);
    a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        bypass_cnt_q <= BYPASS_LIMIT);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Testbench for dcache_port_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model.

module tb_dcache_port_arbiter;

    localparam int MAXB = 8;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [2:0] req_i;
    logic [2:0] we_i;
    logic [2:0] gnt_o;
    logic       cache_req_o;
    logic       cache_we_o;
    logic [1:0] cache_port_o;
    logic       cache_gnt_i;
    logic       cache_done_i;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the controller, whether the controller has
    // accepted, and how many times a waiting store has been passed over.
    int m_owner;     // -1 when nobody owns the port
    bit m_accepted;
    int m_passed;

    logic [2:0] e_gnt;
    logic       e_req;
    logic       e_we;
    logic [1:0] e_port;
    logic       e_busy;

    dcache_port_arbiter #(.MAX_BYPASS(MAXB)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .we_i         (we_i),
        .gnt_o        (gnt_o),
        .cache_req_o  (cache_req_o),
        .cache_we_o   (cache_we_o),
        .cache_port_o (cache_port_o),
        .cache_gnt_i  (cache_gnt_i),
        .cache_done_i (cache_done_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        m_owner    = -1;
        m_accepted = 1'b0;
        m_passed   = 0;
    endtask

    // One rising edge of the reference model using the currently driven inputs
    task automatic model_advance();
        if (m_owner < 0) begin
            if (req_i != 3'b000) begin
                if (req_i[2] && m_passed == MAXB) m_owner = 2;
                else if (req_i[0])                m_owner = 0;
                else if (req_i[1])                m_owner = 1;
                else                              m_owner = 2;
                m_accepted = 1'b0;
            end
            if (!req_i[2]) m_passed = 0;
        end else if (!m_accepted) begin
            if (cache_gnt_i) begin
                if (m_owner == 2)  m_passed = 0;
                else if (req_i[2]) m_passed = (m_passed + 1 > MAXB) ? MAXB : m_passed + 1;
                if (cache_done_i) m_owner = -1;
                else              m_accepted = 1'b1;
            end else if (!req_i[m_owner]) begin
                m_owner = -1;
            end
        end else if (cache_done_i) begin
            m_owner    = -1;
            m_accepted = 1'b0;
        end
    endtask

    task automatic compute_expected();
        e_gnt  = 3'b000;
        e_req  = 1'b0;
        e_we   = 1'b0;
        e_port = 2'd0;
        e_busy = 1'b0;
        if (m_owner >= 0) begin
            e_busy = 1'b1;
            e_port = 2'(m_owner);
            if (!m_accepted) begin
                e_req = req_i[m_owner];
                e_we  = we_i[m_owner];
                if (cache_gnt_i) e_gnt = 3'(1 << m_owner);
            end
        end
    endtask

    task automatic apply(input logic [2:0] r, input logic [2:0] w,
                         input logic g, input logic d);
        req_i        = r;
        we_i         = w;
        cache_gnt_i  = g;
        cache_done_i = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (!rst_ni) model_reset();
        else         model_advance();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        apply(3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        apply(3'($urandom), 3'($urandom), 1'b1, 1'b1);
        n_checks++;
        if ({gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b req=%b we=%b port=%0d busy=%b, required all 0",
                     gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o);
        end
        tick();
        tick();
        n_checks++;
        if ({gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_held: got gnt=%b req=%b we=%b port=%0d busy=%b, required all 0",
                     gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o);
        end
        rst_ni = 1'b1;
        apply(3'b000, 3'b000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        apply(3'b111, 3'b000, 1'b0, 1'b0);
        n_checks++;
        if (cache_req_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_idle: got req=%b busy=%b, required 0 0", cache_req_o, busy_o);
        end
        tick();
        apply(3'b111, 3'b000, 1'b1, 1'b0);
        n_checks++;
        if (cache_port_o !== 2'd0 || cache_req_o !== 1'b1 || gnt_o !== 3'b001) begin
            n_fail++;
            $display("FAIL sim_first: got port=%0d req=%b gnt=%b, required 0 1 001",
                     cache_port_o, cache_req_o, gnt_o);
        end
        tick();
        apply(3'b110, 3'b000, 1'b0, 1'b1);
        n_checks++;
        if (cache_port_o !== 2'd0 || cache_req_o !== 1'b0 || gnt_o !== 3'b000 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_wait: got port=%0d req=%b gnt=%b busy=%b, required 0 0 000 1",
                     cache_port_o, cache_req_o, gnt_o, busy_o);
        end
        tick();
        apply(3'b110, 3'b000, 1'b0, 1'b0);
        tick();
        apply(3'b110, 3'b000, 1'b1, 1'b1);
        n_checks++;
        if (cache_port_o !== 2'd1 || gnt_o !== 3'b010) begin
            n_fail++;
            $display("FAIL sim_load_first: got port=%0d gnt=%b, required 1 010", cache_port_o, gnt_o);
        end
        tick();
        apply(3'b100, 3'b100, 1'b0, 1'b0);
        tick();
        apply(3'b100, 3'b100, 1'b1, 1'b1);
        n_checks++;
        if (cache_port_o !== 2'd2 || gnt_o !== 3'b100 || cache_we_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_store_after: got port=%0d gnt=%b we=%b, required 2 100 1",
                     cache_port_o, gnt_o, cache_we_o);
        end
        tick();
        apply(3'b000, 3'b000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_starvation();
        logic [2:0] pat;
        logic [1:0] want;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            for (int g = 0; g <= MAXB; g++) begin
                pat  = (g % 2 == 0) ? 3'b101 : 3'b110;
                want = (g == MAXB) ? 2'd2 : ((g % 2 == 0) ? 2'd0 : 2'd1);
                apply(pat, 3'b100, 1'b0, 1'b0);
                tick();
                apply(pat, 3'b100, 1'b1, 1'b1);
                n_checks++;
                if (cache_port_o !== want) begin
                    n_fail++;
                    $display("FAIL starve_r%0d_g%0d: got port=%0d, required %0d",
                             round, g + 1, cache_port_o, want);
                end
                tick();
            end
        end
        apply(3'b000, 3'b000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_store_gnt_done();
        do_reset();
        apply(3'b100, 3'b100, 1'b0, 1'b0);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL store_pre_busy: got %b, required 0", busy_o);
        end
        tick();
        apply(3'b100, 3'b100, 1'b1, 1'b1);
        n_checks++;
        if (busy_o !== 1'b1 || cache_port_o !== 2'd2 || cache_we_o !== 1'b1 ||
            cache_req_o !== 1'b1 || gnt_o !== 3'b100) begin
            n_fail++;
            $display("FAIL store_req: got busy=%b port=%0d we=%b req=%b gnt=%b, required 1 2 1 1 100",
                     busy_o, cache_port_o, cache_we_o, cache_req_o, gnt_o);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(3'b000, 3'b000, 1'b0, 1'b0);
            n_checks++;
            if (busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL store_post_busy_%0d: got %b, required 0", i, busy_o);
            end
            tick();
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        apply(3'b010, 3'b000, 1'b0, 1'b0);
        tick();
        apply(3'b000, 3'b000, 1'b0, 1'b0);
        n_checks++;
        if (gnt_o !== 3'b000 || cache_port_o !== 2'd1 || cache_req_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_req: got gnt=%b port=%0d req=%b busy=%b, required 000 1 0 1",
                     gnt_o, cache_port_o, cache_req_o, busy_o);
        end
        tick();
        apply(3'b001, 3'b000, 1'b0, 1'b0);
        n_checks++;
        if (busy_o !== 1'b0 || gnt_o !== 3'b000) begin
            n_fail++;
            $display("FAIL withdraw_idle: got busy=%b gnt=%b, required 0 000", busy_o, gnt_o);
        end
        tick();
        apply(3'b001, 3'b001, 1'b1, 1'b1);
        n_checks++;
        if (cache_port_o !== 2'd0 || gnt_o !== 3'b001 || cache_we_o !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_next: got port=%0d gnt=%b we=%b, required 0 001 1",
                     cache_port_o, gnt_o, cache_we_o);
        end
        tick();
        apply(3'b000, 3'b000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        apply(3'b001, 3'b000, 1'b0, 1'b0);
        tick();
        apply(3'b001, 3'b000, 1'b1, 1'b0);
        tick();
        apply(3'b000, 3'b000, 1'b0, 1'b0);
        n_checks++;
        if (busy_o !== 1'b1 || cache_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_pre: got busy=%b req=%b, required 1 0", busy_o, cache_req_o);
        end
        rst_ni = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL rstwait_async: got gnt=%b req=%b we=%b port=%0d busy=%b, required all 0",
                     gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o);
        end
        tick();
        rst_ni = 1'b1;
        apply(3'b000, 3'b000, 1'b0, 1'b1);
        tick();
        apply(3'b000, 3'b000, 1'b0, 1'b0);
        n_checks++;
        if ({gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL rstwait_late_done: got gnt=%b req=%b we=%b port=%0d busy=%b, required all 0",
                     gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o);
        end
        tick();
    endtask

    task automatic test_done_in_idle();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(3'b000, 3'($urandom), 1'($urandom), 1'b1);
            n_checks++;
            if ({gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o} !== 8'b0) begin
                n_fail++;
                $display("FAIL idle_done_%0d: got gnt=%b req=%b we=%b port=%0d busy=%b, required all 0",
                         i, gnt_o, cache_req_o, cache_we_o, cache_port_o, busy_o);
            end
            tick();
        end
        apply(3'b000, 3'b000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [2:0] r;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            r    = 3'($urandom);
            r[2] = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) r = 3'b000;
            apply(r, 3'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 4));
            compute_expected();
            n_checks++;
            if (gnt_o !== e_gnt) begin
                n_fail++;
                $display("FAIL rand_gnt cyc %0d: got %b, required %b", cyc, gnt_o, e_gnt);
            end
            n_checks++;
            if (cache_req_o !== e_req) begin
                n_fail++;
                $display("FAIL rand_req cyc %0d: got %b, required %b", cyc, cache_req_o, e_req);
            end
            n_checks++;
            if (cache_we_o !== e_we) begin
                n_fail++;
                $display("FAIL rand_we cyc %0d: got %b, required %b", cyc, cache_we_o, e_we);
            end
            n_checks++;
            if (cache_port_o !== e_port) begin
                n_fail++;
                $display("FAIL rand_port cyc %0d: got %0d, required %0d", cyc, cache_port_o, e_port);
            end
            n_checks++;
            if (busy_o !== e_busy) begin
                n_fail++;
                $display("FAIL rand_busy cyc %0d: got %b, required %b", cyc, busy_o, e_busy);
            end
            tick();
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_i        = 3'b000;
        we_i         = 3'b000;
        cache_gnt_i  = 1'b0;
        cache_done_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        test_reset();
        test_simultaneous();
        test_starvation();
        test_store_gnt_done();
        test_withdraw();
        test_reset_in_wait();
        test_done_in_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
